hd_codeword_pairer: RTL
=======================

Name: hd_codeword_pairer

Overview:
- Upstream stage of the Hamming(7,4) pair decoder.
- Accepts a stream of 4-bit data nibbles, each with a required single-bit error position.
- Hamming-encodes each nibble, flips exactly one bit, and pairs consecutive nibbles into {code_word1, code_word2}.
- Presents each pair on a registered valid/ready output that feeds the decoder's code_word1/code_word2 inputs directly.

Parameters:
- PAIR_CNT_W, 8: width of the optional pair counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  nibble offered
- in_ready  out  1  nibble accepted when in_valid && in_ready
- in_data  in  4  data bits x1..x4 (bit3 = x1)
- in_err_pos  in  3  codeword bit index (0..6) to invert
- out_valid  out  1  pair available
- out_ready  in  1  downstream accepts pair
- code_word1  out  7  first encoded word of pair
- code_word2  out  7  second encoded word of pair
- err_flag  out  1  sticky: an illegal err_pos (7) was accepted
- pair_cnt  out  PAIR_CNT_W  pairs delivered (HDP_PAIR_CNT_EN only)

Behaviour:
- Reset is asynchronous, active-low; one clock domain. At reset: out_valid=0, code_word1=0, code_word2=0, err_flag=0, pair_cnt=0, FSM=S_W1.
- Encoding, for nibble d:
  - cw[3:0] = d
  - cw[6] = d3^d2^d1
  - cw[5] = d3^d2^d0
  - cw[4] = d3^d1^d0
  - The transmitted word is cw with bit in_err_pos inverted.
  - If in_err_pos==7, bit 0 is inverted and err_flag sets (it stays set until reset).
- FSM states:
  - S_W1: waiting for first word. in_ready=1. On accept, store the encoded word in the word1 holding register and go to S_W2.
  - S_W2: waiting for second word. in_ready=1. On accept, load code_word1 from the holding register and code_word2 from the newly encoded word, set out_valid=1, and go to S_OUT.
  - S_OUT: out_valid=1 and the outputs are held stable. in_ready = out_ready.
    - out_ready=1 and in_valid=1: the pair retires and the new first word is captured in the same cycle; go to S_W2.
    - out_ready=1 and in_valid=0: the pair retires; out_valid=0; go to S_W1.
    - out_ready=0: stay in S_OUT; nothing is accepted.
- Latency: the pair is visible at out_valid the cycle after the second input handshake.
- Throughput: one pair every 2 cycles with no bubbles.
- code_word1/2 change only on a load in S_W2. They hold their last value after retire; they are not cleared.
- Ordering: the first-accepted nibble always goes to code_word1.
- Reset mid-pair (in S_W2) discards the held word; the next accepted nibble becomes word1.
- in_data and in_err_pos are ignored unless a handshake occurs.

Optional Feature:
- Macro HDP_PAIR_CNT_EN.
- Defined:
  - pair_cnt increments by 1 on every output handshake (out_valid && out_ready).
  - It wraps modulo 2^PAIR_CNT_W.
  - It resets to 0.
- Undefined:
  - The pair_cnt port is absent; there is no counter logic.

Decomposition:
- Package hdp_pkg holds:
  - the FSM state enum (S_W1, S_W2, S_OUT);
  - the codeword width constant CW_W=7;
  - the data width DATA_W=4;
  - the ILLEGAL_POS=7 constant.
- Sub-module hd_encode74 (combinational) takes data and err_pos and returns the encoded word and an illegal flag. The top level owns the FSM and the registers.

Test Plan:
- Clean pair, out_ready=1:
  - nibbles 4'hB (err 0) then 4'h0 (err 6) -> next cycle out_valid=1, code_word1=7'h1A, code_word2=7'h40.
  - Output handshake the same cycle; err_flag=0.
- Backpressure:
  - pair 4'hF (err 3), 4'hF (err 4), out_ready=0 for 5 cycles -> code_word1=7'h77, code_word2=7'h6F held stable, in_ready=0 throughout.
  - On release, retire in 1 cycle.
- Back-to-back stream:
  - 8 nibbles with in_valid=1 and out_ready=1 every cycle -> 4 pairs, one out_valid pulse every 2 cycles, correct order.
  - pair_cnt=4 when HDP_PAIR_CNT_EN is defined.
- Illegal position:
  - nibble 4'hB with err_pos 7 -> bit0 flipped (word 7'h1A), err_flag=1.
  - err_flag stays 1 over 10 later legal pairs.
- Reset mid-pair:
  - accept 4'h5, assert rst_n=0 asynchronously mid-cycle -> out_valid=0, code words=0, err_flag=0 immediately.
  - After release, nibbles 4'h1 (err 0), 4'h2 (err 0) -> code_word1 built from 4'h1.
- Decoder loopback:
  - Drive this block into the pair decoder with random nibbles and random err_pos 0..6 -> decoder out_n matches the golden model for 1000 pairs.

Source files
------------

// File: rtl/hd_codeword_pairer_pkg.sv
// Shared types and constants for the Hamming(7,4) codeword pairer (package hdp_pkg).
package hdp_pkg;

  localparam int          CW_W        = 7;
  localparam int          DATA_W      = 4;
  localparam logic [2:0]  ILLEGAL_POS = 3'd7;

  typedef enum logic [1:0] {
    S_W1,
    S_W2,
    S_OUT
  } state_e;

endpackage

// File: rtl/hd_encode74.sv
// Combinational Hamming(7,4) encoder that inverts one chosen codeword bit.
// An out-of-range position (7) inverts bit 0 and raises illegal.
module hd_encode74
  import hdp_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [2:0]        err_pos,
  output logic [CW_W-1:0]   word,
  output logic              illegal
);

  logic [CW_W-1:0] cw;
  logic [2:0]      flip_pos;

  always_comb begin
    cw       = {data[3] ^ data[2] ^ data[1],
                data[3] ^ data[2] ^ data[0],
                data[3] ^ data[1] ^ data[0],
                data};
    illegal  = (err_pos == ILLEGAL_POS);
    flip_pos = illegal ? 3'd0 : err_pos;
    word     = cw ^ (CW_W'(1) << flip_pos);
  end

endmodule

// File: rtl/hd_codeword_pairer.sv
// Pairs consecutive encoded nibbles into {code_word1, code_word2} behind a valid/ready output.
// Optional pair counter enabled by defining HDP_PAIR_CNT_EN.
module hd_codeword_pairer
  import hdp_pkg::*;
#(
  parameter int PAIR_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [2:0]            in_err_pos,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CW_W-1:0]       code_word1,
  output logic [CW_W-1:0]       code_word2,
  output logic                  err_flag
`ifdef HDP_PAIR_CNT_EN
  ,
  output logic [PAIR_CNT_W-1:0] pair_cnt
`endif
);

  state_e          state_q, state_d;
  logic [CW_W-1:0] hold_q, hold_d;
  logic [CW_W-1:0] cw1_q, cw1_d;
  logic [CW_W-1:0] cw2_q, cw2_d;
  logic            out_valid_q, out_valid_d;
  logic            err_q, err_d;
  logic [CW_W-1:0] enc_word;
  logic            enc_illegal;
  logic            accept;

  hd_encode74 u_enc (
    .data    (in_data),
    .err_pos (in_err_pos),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // While a pair is pending, a new first word may only enter as the pair retires.
  assign in_ready = (state_q == S_OUT) ? out_ready : 1'b1;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    cw1_d       = cw1_q;
    cw2_d       = cw2_q;
    out_valid_d = out_valid_q;
    err_d       = err_q | (accept && enc_illegal);
    case (state_q)
      S_W1: begin
        if (accept) begin
          hold_d  = enc_word;
          state_d = S_W2;
        end
      end
      S_W2: begin
        if (accept) begin
          cw1_d       = hold_q;
          cw2_d       = enc_word;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            hold_d  = enc_word;
            state_d = S_W2;
          end else begin
            state_d = S_W1;
          end
        end
      end
      default: state_d = S_W1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; every flop, including the holding register, takes the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_W1;
      hold_q      <= '0;
      cw1_q       <= '0;
      cw2_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cw1_q       <= cw1_d;
      cw2_q       <= cw2_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign code_word1 = cw1_q;
  assign code_word2 = cw2_q;
  assign err_flag   = err_q;

`ifdef HDP_PAIR_CNT_EN
  logic [PAIR_CNT_W-1:0] pair_cnt_q, pair_cnt_d;

  always_comb begin
    pair_cnt_d = pair_cnt_q;
    if (out_valid_q && out_ready) pair_cnt_d = pair_cnt_q + PAIR_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pair_cnt_q <= '0;
    else        pair_cnt_q <= pair_cnt_d;
  end

  assign pair_cnt = pair_cnt_q;
`endif

endmodule
